// File: rtl/pa_spsram_512x38_acc.sv
// Access controller for the LSU 512x38 single-port SRAM macro: zero-fill after reset,
// in-order read/write issue, and a 2-entry read response FIFO with credit-based backpressure.
module pa_spsram_512x38_acc #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 38,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [2];
  logic                  fifo_wptr_q, fifo_rptr_q;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  push, pop, accept;
  logic [2:0]            occ;

  assign pop       = rsp_vld & rsp_rdy;
  assign push      = rd_pend_q;
  assign rsp_vld   = (fifo_cnt_q != 2'd0);
  assign rsp_rdata = fifo_mem_q[fifo_rptr_q];
  // Credits: entries held plus the read in flight, less the one leaving this cycle.
  assign occ        = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
  assign init_done  = (INIT_EN == 0) || ((state_q == StRun) && !cpurst);
  assign rd_pend_d  = accept & ~req_wr;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    req_rdy    = 1'b0;
    accept     = 1'b0;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = '1;
    sram_a     = '0;
    sram_d     = '0;
    if (!cpurst) begin
      unique case (state_q)
        StInit: begin
          sram_cen   = 1'b0;
          sram_gwen  = 1'b0;
          sram_wen   = '0;
          sram_a     = init_cnt_q;
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          if (init_cnt_q == LastAddr) state_d = StRun;
        end
        StRun: begin
          req_rdy = (occ < 3'd2);
          accept  = req_vld & req_rdy;
          if (accept) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
              sram_gwen = 1'b0;
              sram_wen  = ~req_wmask;
              sram_d    = req_wdata;
            end
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= (INIT_EN != 0) ? StInit : StRun;
      init_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rd_pend_q  <= rd_pend_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_mem_q[fifo_wptr_q] <= sram_q;
        fifo_wptr_q             <= ~fifo_wptr_q;
      end
      if (pop) fifo_rptr_q <= ~fifo_rptr_q;
    end
  end

endmodule

// File: tb/tb_pa_spsram_512x38_acc.sv
// Directed bench for pa_spsram_512x38_acc with a behavioural 512x38 macro model attached.
module tb_pa_spsram_512x38_acc;

  localparam int AW = 9;
  localparam int DW = 38;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          cpurst;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [512];

  always #5 clk = ~clk;

  // Macro model: bit-masked write, read data on Q the cycle after issue.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < DW; b++) if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  pa_spsram_512x38_acc dut (
    .forever_cpuclk(clk),
    .cpurst        (cpurst),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_rdata     (rsp_rdata),
    .init_done     (init_done),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  always @(negedge clk) begin
    if (!cpurst && dut.rd_pend_q && dut.fifo_cnt_q == 2'd2 && !(rsp_vld && rsp_rdy)) begin
      errors++;
      $error("FAIL fifo_overflow observed push into full FIFO required none");
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] base;
    base = 38'h15_0000_0000;
    return base | {29'd0, a} * 38'h0_0101_0101;
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    chk("wr_rdy", req_rdy, 1'b1);
    chk("wr_pins", {sram_cen, sram_gwen, sram_wen, sram_d, sram_a}, {1'b0, 1'b0, ~m, d, a});
    cyc();
    req_vld = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
    #1;
    chk("rd_rdy", req_rdy, 1'b1);
    chk("rd_pins", {sram_cen, sram_gwen, sram_wen, sram_a}, {1'b0, 1'b1, ONES, a});
    cyc();
    req_vld = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd(a);
    #1;
    chk({tag, "_lat"}, rsp_vld, 1'b0);
    cyc();
    chk({tag, "_vld"}, rsp_vld, 1'b1);
    chk({tag, "_data"}, rsp_rdata, exp);
    cyc();
  endtask

  initial begin
    cpurst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
    cyc();
    cyc();
    chk("rst_req_rdy", req_rdy, 1'b0);
    chk("rst_rsp", {rsp_vld, rsp_rdata}, 39'd0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b1, 1'b1, ONES, 9'd0, 38'd0});

    // Zero-fill walk; a pending read request must be held off throughout.
    cpurst = 1'b0; req_vld = 1'b1;
    for (int i = 0; i < 512; i++) begin
      #1;
      chk("init_walk", {init_done, req_rdy, sram_cen, sram_gwen, sram_wen, sram_d, sram_a},
          {4'b0000, 38'd0, 38'd0, 9'(i)});
      cyc();
    end
    req_vld = 1'b0;
    #1;
    chk("init_done", init_done, 1'b1);
    rd_chk("rd0_zero", 9'd0, '0);
    rd_chk("rd511_zero", 9'd511, '0);
    #1;
    chk("idle_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {1'b1, 1'b1, ONES, 9'd0, 38'd0});

    // Full write then read-after-write.
    wr(9'd5, 38'h3F_FFFF_FFFF, ONES);
    rd_chk("raw5", 9'd5, 38'h3F_FFFF_FFFF);

    // Masked write over a zeroed entry.
    wr(9'd7, ONES, 38'h00_0000_00FF);
    rd_chk("mask7", 9'd7, 38'h00_0000_00FF);

    // Backpressure: only two reads held while rsp_rdy=0.
    wr(9'd1, 38'h11_1111_1111, ONES);
    wr(9'd2, 38'h22_2222_2222, ONES);
    wr(9'd3, 38'h33_3333_3333, ONES);
    rsp_rdy = 1'b0;
    rd(9'd1);
    rd(9'd2);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'd3;
    #1;
    chk("bp_rdy_low1", {req_rdy, sram_cen}, 2'b01);
    cyc();
    #1;
    chk("bp_rdy_low2", req_rdy, 1'b0);
    chk("bp_head_a1", {rsp_vld, rsp_rdata}, {1'b1, 38'h11_1111_1111});
    cyc();
    rsp_rdy = 1'b1;
    #1;
    chk("bp_rdy_comb", {req_rdy, sram_cen, sram_a}, {2'b10, 9'd3});
    chk("bp_pop_a1", {rsp_vld, rsp_rdata}, {1'b1, 38'h11_1111_1111});
    cyc();
    req_vld = 1'b0;
    #1;
    chk("bp_pop_a2", {rsp_vld, rsp_rdata}, {1'b1, 38'h22_2222_2222});
    cyc();
    chk("bp_pop_a3", {rsp_vld, rsp_rdata}, {1'b1, 38'h33_3333_3333});
    cyc();
    chk("bp_empty", rsp_vld, 1'b0);

    // Streaming: 100 back-to-back reads over a patterned window.
    for (int i = 0; i < 8; i++) wr(9'(16 + i), pat(9'(16 + i)), ONES);
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'(16 + i % 8);
      end else begin
        req_vld = 1'b0;
      end
      #1;
      if (i < 100) chk("stream_rdy", req_rdy, 1'b1);
      if (i >= 2) chk("stream_rsp", {rsp_vld, rsp_rdata}, {1'b1, pat(9'(16 + (i - 2) % 8))});
      cyc();
    end
    #1;
    chk("stream_end", rsp_vld, 1'b0);

    // Reset one cycle after a read issue drops the read and restarts the walk.
    rd(9'd5);
    cpurst = 1'b1;
    #1;
    chk("mrst_pins", {sram_cen, sram_gwen, req_rdy, rsp_vld}, 4'b1100);
    cyc();
    chk("mrst_rsp1", {rsp_vld, sram_cen}, 2'b01);
    cyc();
    chk("mrst_rsp2", rsp_vld, 1'b0);
    cpurst = 1'b0;
    #1;
    chk("mrst_restart", {init_done, sram_cen, sram_a}, {2'b00, 9'd0});
    cyc();
    chk("mrst_a1", {sram_cen, sram_a}, {1'b0, 9'd1});
    repeat (511) cyc();
    chk("mrst_done", {init_done, rsp_vld}, 2'b10);
    rd_chk("mrst_zero5", 9'd5, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
